video_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor to the fixed 1024x768 generator.

---
 rtl/vtg_pkg.sv | 34 +++
 rtl/vtg_axis_counter.sv | 61 ++++++
 rtl/video_timing_gen.sv | 195 +++++++++++++++++++
 tb/tb_video_timing_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// vtg_pkg: shared timing record and validation rule for video_timing_gen.
package vtg_pkg;

  localparam int VTG_FIELD_W = 16;

  typedef struct packed {
    logic [VTG_FIELD_W-1:0] h_act;
    logic [VTG_FIELD_W-1:0] h_fp;
    logic [VTG_FIELD_W-1:0] h_sync;
    logic [VTG_FIELD_W-1:0] h_bp;
    logic [VTG_FIELD_W-1:0] v_act;
    logic [VTG_FIELD_W-1:0] v_fp;
    logic [VTG_FIELD_W-1:0] v_sync;
    logic [VTG_FIELD_W-1:0] v_bp;
  } vtg_timing_t;

  // A timing set is usable when the active and sync spans are non-empty and
  // each total (taken on the full 16b fields, two bits wider so nothing wraps)
  // fits a counter of the given width, i.e. total-1 <= 2**w - 1.
  function automatic logic vtg_valid(input vtg_timing_t t, input int h_w, input int v_w);
    logic [VTG_FIELD_W+1:0] h_tot;
    logic [VTG_FIELD_W+1:0] v_tot;
    logic [31:0]            h_lim;
    logic [31:0]            v_lim;
    h_tot = {2'b00, t.h_act} + {2'b00, t.h_fp} + {2'b00, t.h_sync} + {2'b00, t.h_bp};
    v_tot = {2'b00, t.v_act} + {2'b00, t.v_fp} + {2'b00, t.v_sync} + {2'b00, t.v_bp};
    h_lim = 32'd1 << h_w;
    v_lim = 32'd1 << v_w;
    return (t.h_act != '0) && (t.h_sync != '0) &&
           (t.v_act != '0) && (t.v_sync != '0) &&
           ({14'd0, h_tot} <= h_lim) && ({14'd0, v_tot} <= v_lim);
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one raster axis (pixels or lines). Counts 0..tot-1 while
// enabled and registers the sync level for the count it is about to show.
// Terminal count uses the timing in force now; the sync/blank decode uses the
// timing that will be in force next cycle, so a timing swap at the frame
// boundary is already reflected on the first 0,0 cycle.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int   W        = 11,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] cur_act,
  input  logic [W-1:0] cur_fp,
  input  logic [W-1:0] cur_sync,
  input  logic [W-1:0] cur_bp,
  input  logic [W-1:0] nxt_act,
  input  logic [W-1:0] nxt_fp,
  input  logic [W-1:0] nxt_sync,
  output logic [W-1:0] count,
  output logic         at_end,
  output logic [W-1:0] count_nxt,
  output logic         blank_nxt,
  output logic         sync
);

  logic [W-1:0] cur_tot_m1;
  logic [W-1:0] sync_start;
  logic [W-1:0] sync_end;
  logic         sync_nxt;

  assign cur_tot_m1 = cur_act + cur_fp + cur_sync + cur_bp - W'(1);
  assign at_end     = (count == cur_tot_m1);

  // Next count: advance when enabled, wrapping at the terminal count.
  always_comb begin
    count_nxt = count;
    if (en) begin
      count_nxt = at_end ? '0 : count + W'(1);
    end
  end

  assign sync_start = nxt_act + nxt_fp;
  assign sync_end   = sync_start + nxt_sync;
  assign sync_nxt   = (count_nxt >= sync_start) && (count_nxt < sync_end);
  assign blank_nxt  = (count_nxt >= nxt_act);

  // Count and sync registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sync  <= ~SYNC_POL;
    end else begin
      count <= count_nxt;
      sync  <= sync_nxt ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// Build option VTG_RUNTIME_CFG_EN: when defined, a new timing set can be
// offered through the cfg_* handshake and is swapped in on a frame boundary.
// When undefined, timing is fixed to the parameters and the cfg outputs are 0.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no timing held; cfg_ready_out high
// ST_PENDING | timing captured; checked next cycle, then held to frame end
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int   H_ACTIVE  = 1024,
  parameter int   H_FP      = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BP      = 160,
  parameter int   V_ACTIVE  = 768,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BP      = 29,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   HCOUNT_W  = 11,
  parameter int   VCOUNT_W  = 10
) (
  input  logic                vclock_in,
  input  logic                reset_n_in,
  input  logic                cfg_valid_in,
  output logic                cfg_ready_out,
  input  vtg_timing_t         cfg_timing_in,
  output logic                cfg_applied_out,
  output logic                cfg_err_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                blank_out,
  output logic                line_start_out,
  output logic                frame_start_out
);

  localparam vtg_timing_t PARAM_TIMING = '{
    h_act:  VTG_FIELD_W'(H_ACTIVE),
    h_fp:   VTG_FIELD_W'(H_FP),
    h_sync: VTG_FIELD_W'(H_SYNC),
    h_bp:   VTG_FIELD_W'(H_BP),
    v_act:  VTG_FIELD_W'(V_ACTIVE),
    v_fp:   VTG_FIELD_W'(V_FP),
    v_sync: VTG_FIELD_W'(V_SYNC),
    v_bp:   VTG_FIELD_W'(V_BP)
  };

  vtg_timing_t         cur_t;
  vtg_timing_t         nxt_t;
  logic                h_end;
  logic                v_end;
  logic                frame_end;
  logic [HCOUNT_W-1:0] h_nxt;
  logic [VCOUNT_W-1:0] v_nxt;
  logic                h_blank_nxt;
  logic                v_blank_nxt;
  logic                blank_q;
  logic                line_start_q;
  logic                frame_start_q;

  vtg_axis_counter #(.W(HCOUNT_W), .SYNC_POL(HSYNC_POL)) u_h_axis (
    .clk       (vclock_in),
    .rst_n     (reset_n_in),
    .en        (1'b1),
    .cur_act   (cur_t.h_act[HCOUNT_W-1:0]),
    .cur_fp    (cur_t.h_fp[HCOUNT_W-1:0]),
    .cur_sync  (cur_t.h_sync[HCOUNT_W-1:0]),
    .cur_bp    (cur_t.h_bp[HCOUNT_W-1:0]),
    .nxt_act   (nxt_t.h_act[HCOUNT_W-1:0]),
    .nxt_fp    (nxt_t.h_fp[HCOUNT_W-1:0]),
    .nxt_sync  (nxt_t.h_sync[HCOUNT_W-1:0]),
    .count     (hcount_out),
    .at_end    (h_end),
    .count_nxt (h_nxt),
    .blank_nxt (h_blank_nxt),
    .sync      (hsync_out)
  );

  vtg_axis_counter #(.W(VCOUNT_W), .SYNC_POL(VSYNC_POL)) u_v_axis (
    .clk       (vclock_in),
    .rst_n     (reset_n_in),
    .en        (h_end),
    .cur_act   (cur_t.v_act[VCOUNT_W-1:0]),
    .cur_fp    (cur_t.v_fp[VCOUNT_W-1:0]),
    .cur_sync  (cur_t.v_sync[VCOUNT_W-1:0]),
    .cur_bp    (cur_t.v_bp[VCOUNT_W-1:0]),
    .nxt_act   (nxt_t.v_act[VCOUNT_W-1:0]),
    .nxt_fp    (nxt_t.v_fp[VCOUNT_W-1:0]),
    .nxt_sync  (nxt_t.v_sync[VCOUNT_W-1:0]),
    .count     (vcount_out),
    .at_end    (v_end),
    .count_nxt (v_nxt),
    .blank_nxt (v_blank_nxt),
    .sync      (vsync_out)
  );

  assign frame_end = h_end & v_end;

  // Blank and strobes registered from the next count so they line up with it.
  // Out of reset the counters sit at 0,0, so both strobes start high.
  always_ff @(posedge vclock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      blank_q       <= 1'b0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      blank_q       <= h_blank_nxt | v_blank_nxt;
      line_start_q  <= (h_nxt == '0);
      frame_start_q <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

  assign blank_out       = blank_q;
  assign line_start_out  = line_start_q;
  assign frame_start_out = frame_start_q;

`ifdef VTG_RUNTIME_CFG_EN

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]  state_q;
  vtg_timing_t act_q;
  vtg_timing_t pend_q;
  logic        pend_ok_q;
  logic        applied_q;
  logic        err_q;
  logic        capture;
  logic        apply;
  logic        reject;
  logic        unused_bits;

  assign capture = cfg_valid_in && (state_q == ST_IDLE);
  assign reject  = (state_q == ST_PENDING) && !pend_ok_q;
  assign apply   = (state_q == ST_PENDING) && pend_ok_q && frame_end;

  // Reload FSM: capture, check one cycle later, hold until the frame boundary.
  always_ff @(posedge vclock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= ST_IDLE;
      act_q     <= PARAM_TIMING;
      pend_q    <= '0;
      pend_ok_q <= 1'b0;
      applied_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      applied_q <= apply;
      err_q     <= reject;
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            pend_q    <= cfg_timing_in;
            pend_ok_q <= vtg_valid(cfg_timing_in, HCOUNT_W, VCOUNT_W);
            state_q   <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (apply) begin
            act_q <= pend_q;
          end
          if (apply || reject) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cur_t           = act_q;
  assign nxt_t           = apply ? pend_q : act_q;
  assign cfg_ready_out   = (state_q == ST_IDLE);
  assign cfg_applied_out = applied_q;
  assign cfg_err_out     = err_q;
  assign unused_bits     = ^{cur_t, nxt_t};

`else

  logic unused_bits;

  assign cur_t           = PARAM_TIMING;
  assign nxt_t           = PARAM_TIMING;
  assign cfg_ready_out   = 1'b0;
  assign cfg_applied_out = 1'b0;
  assign cfg_err_out     = 1'b0;
  assign unused_bits     = ^{cfg_valid_in, cfg_timing_in, cur_t, nxt_t, frame_end};

`endif

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
module tb_video_timing_gen;
  import vtg_pkg::*;

`ifdef VTG_RUNTIME_CFG_EN
  localparam logic EXP_READY_IDLE = 1'b1;
`else
  localparam logic EXP_READY_IDLE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  vtg_timing_t cfg_timing;
  logic        cfg_ready, cfg_applied, cfg_err;
  logic [3:0]  hcount;
  logic [2:0]  vcount;
  logic        hsync, vsync, blank, line_start, frame_start;

  int checks = 0;
  int failures = 0;
  int k = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HCOUNT_W(4), .VCOUNT_W(3)
  ) dut (
    .vclock_in(clk), .reset_n_in(rst_n),
    .cfg_valid_in(cfg_valid), .cfg_ready_out(cfg_ready), .cfg_timing_in(cfg_timing),
    .cfg_applied_out(cfg_applied), .cfg_err_out(cfg_err),
    .hcount_out(hcount), .vcount_out(vcount), .hsync_out(hsync), .vsync_out(vsync),
    .blank_out(blank), .line_start_out(line_start), .frame_start_out(frame_start)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k = k + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic set_new_timing();
    cfg_timing = '{h_act:16'd6, h_fp:16'd1, h_sync:16'd2, h_bp:16'd1,
                   v_act:16'd3, v_fp:16'd1, v_sync:16'd1, v_bp:16'd1};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (hcount !== 4'd0) begin failures++; $display("FAIL reset_hcount got=%0d exp=0", hcount); end
    checks++; if (vcount !== 3'd0) begin failures++; $display("FAIL reset_vcount got=%0d exp=0", vcount); end
    checks++; if (hsync !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
    checks++; if (blank !== 1'b0) begin failures++; $display("FAIL reset_blank got=%b exp=0", blank); end
    checks++; if (cfg_ready !== EXP_READY_IDLE) begin failures++; $display("FAIL reset_ready got=%b exp=%b", cfg_ready, EXP_READY_IDLE); end
    checks++; if (cfg_applied !== 1'b0) begin failures++; $display("FAIL reset_applied got=%b exp=0", cfg_applied); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    checks++; if (line_start !== 1'b1 || frame_start !== 1'b1) begin failures++; $display("FAIL reset_strobes got=%b%b exp=11", line_start, frame_start); end
    rst_n = 1'b1;
    k = 0;
  endtask

  // Two full frames under parameter timing: Htot 14, Vtot 8.
  task automatic test_count();
    int eh, ev, fs_cnt;
    logic e_hs, e_vs, e_bl, e_ls, e_fs;
    do_reset();
    fs_cnt = 0;
    while (k < 224) begin
      eh = k % 14;
      ev = (k / 14) % 8;
      e_hs = !(eh >= 10 && eh <= 12);
      e_vs = !(ev == 5 || ev == 6);
      e_bl = (eh >= 8) || (ev >= 4);
      e_ls = (eh == 0);
      e_fs = (eh == 0) && (ev == 0);
      if (frame_start === 1'b1 && k < 112) fs_cnt++;
      checks++; if (hcount !== 4'(eh)) begin failures++; $display("FAIL count_hcount k=%0d got=%0d exp=%0d", k, hcount, eh); end
      checks++; if (vcount !== 3'(ev)) begin failures++; $display("FAIL count_vcount k=%0d got=%0d exp=%0d", k, vcount, ev); end
      checks++; if (hsync !== e_hs) begin failures++; $display("FAIL count_hsync k=%0d got=%b exp=%b", k, hsync, e_hs); end
      checks++; if (vsync !== e_vs) begin failures++; $display("FAIL count_vsync k=%0d got=%b exp=%b", k, vsync, e_vs); end
      checks++; if (blank !== e_bl) begin failures++; $display("FAIL count_blank k=%0d got=%b exp=%b", k, blank, e_bl); end
      checks++; if (line_start !== e_ls) begin failures++; $display("FAIL count_line_start k=%0d got=%b exp=%b", k, line_start, e_ls); end
      checks++; if (frame_start !== e_fs) begin failures++; $display("FAIL count_frame_start k=%0d got=%b exp=%b", k, frame_start, e_fs); end
      tick();
    end
    checks++; if (fs_cnt != 1) begin failures++; $display("FAIL frame_start_per_112 got=%0d exp=1", fs_cnt); end
  endtask

`ifdef VTG_RUNTIME_CFG_EN
  // Reload mid-frame; old timing holds to frame end, then Htot 10 / Vtot 6.
  task automatic test_cfg_apply();
    int eh, ev, j;
    logic e_hs, e_vs, e_bl;
    do_reset();
    while (k < 30) tick();
    set_new_timing();
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_timing = '{default:16'd0};
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL apply_ready_drop got=%b exp=0", cfg_ready); end
    while (k < 112) begin
      eh = k % 14;
      ev = (k / 14) % 8;
      checks++; if (hcount !== 4'(eh) || vcount !== 3'(ev)) begin failures++; $display("FAIL apply_old_count k=%0d got=%0d,%0d exp=%0d,%0d", k, hcount, vcount, eh, ev); end
      checks++; if (cfg_ready !== 1'b0 || cfg_applied !== 1'b0) begin failures++; $display("FAIL apply_hold k=%0d got ready=%b applied=%b exp 0,0", k, cfg_ready, cfg_applied); end
      tick();
    end
    checks++; if (cfg_applied !== 1'b1) begin failures++; $display("FAIL apply_pulse got=%b exp=1", cfg_applied); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL apply_ready_back got=%b exp=1", cfg_ready); end
    while (k <= 172) begin
      j = k - 112;
      eh = j % 10;
      ev = (j / 10) % 6;
      e_hs = !(eh == 7 || eh == 8);
      e_vs = !(ev == 4);
      e_bl = (eh >= 6) || (ev >= 3);
      checks++; if (hcount !== 4'(eh) || vcount !== 3'(ev)) begin failures++; $display("FAIL apply_new_count k=%0d got=%0d,%0d exp=%0d,%0d", k, hcount, vcount, eh, ev); end
      checks++; if (hsync !== e_hs || vsync !== e_vs || blank !== e_bl) begin failures++; $display("FAIL apply_new_decode k=%0d got hs=%b vs=%b bl=%b exp %b %b %b", k, hsync, vsync, blank, e_hs, e_vs, e_bl); end
      checks++; if (frame_start !== (eh == 0 && ev == 0)) begin failures++; $display("FAIL apply_new_frame_start k=%0d got=%b", k, frame_start); end
      checks++; if (cfg_applied !== (k == 112)) begin failures++; $display("FAIL apply_single_pulse k=%0d got=%b", k, cfg_applied); end
      tick();
    end
  endtask

  // h_sync = 0 is rejected: err pulse, ready back, timing unchanged.
  task automatic test_cfg_reject();
    int eh, ev;
    logic e_hs;
    do_reset();
    while (k < 20) tick();
    cfg_timing = '{h_act:16'd8, h_fp:16'd2, h_sync:16'd0, h_bp:16'd1,
                   v_act:16'd4, v_fp:16'd1, v_sync:16'd2, v_bp:16'd1};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    while (k <= 140) begin
      eh = k % 14;
      ev = (k / 14) % 8;
      e_hs = !(eh >= 10 && eh <= 12);
      checks++; if (hcount !== 4'(eh) || vcount !== 3'(ev)) begin failures++; $display("FAIL reject_count k=%0d got=%0d,%0d exp=%0d,%0d", k, hcount, vcount, eh, ev); end
      checks++; if (hsync !== e_hs) begin failures++; $display("FAIL reject_hsync k=%0d got=%b exp=%b", k, hsync, e_hs); end
      checks++; if (cfg_err !== (k == 22)) begin failures++; $display("FAIL reject_err k=%0d got=%b exp=%b", k, cfg_err, (k == 22)); end
      checks++; if (cfg_ready !== (k != 21)) begin failures++; $display("FAIL reject_ready k=%0d got=%b exp=%b", k, cfg_ready, (k != 21)); end
      checks++; if (cfg_applied !== 1'b0) begin failures++; $display("FAIL reject_applied k=%0d got=%b exp=0", k, cfg_applied); end
      tick();
    end
  endtask

  // Handshake on the frame-end cycle applies one frame later.
  task automatic test_cfg_frame_end();
    int eh, ev, j;
    do_reset();
    while (k < 111) tick();
    checks++; if (hcount !== 4'd13 || vcount !== 3'd7) begin failures++; $display("FAIL fe_position got=%0d,%0d exp=13,7", hcount, vcount); end
    set_new_timing();
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    while (k < 224) begin
      eh = k % 14;
      ev = (k / 14) % 8;
      checks++; if (hcount !== 4'(eh) || vcount !== 3'(ev)) begin failures++; $display("FAIL fe_old_count k=%0d got=%0d,%0d exp=%0d,%0d", k, hcount, vcount, eh, ev); end
      checks++; if (cfg_applied !== 1'b0 || cfg_ready !== 1'b0) begin failures++; $display("FAIL fe_hold k=%0d got applied=%b ready=%b exp 0,0", k, cfg_applied, cfg_ready); end
      tick();
    end
    checks++; if (cfg_applied !== 1'b1 || hcount !== 4'd0 || vcount !== 3'd0) begin failures++; $display("FAIL fe_apply got applied=%b pos=%0d,%0d exp 1 at 0,0", cfg_applied, hcount, vcount); end
    while (k <= 250) begin
      j = k - 224;
      eh = j % 10;
      ev = (j / 10) % 6;
      checks++; if (hcount !== 4'(eh) || vcount !== 3'(ev)) begin failures++; $display("FAIL fe_new_count k=%0d got=%0d,%0d exp=%0d,%0d", k, hcount, vcount, eh, ev); end
      tick();
    end
  endtask

  // Async reset mid-frame with a pending set: immediate reset, parameter timing.
  task automatic test_reset_abort();
    int eh, ev;
    do_reset();
    while (k < 10) tick();
    set_new_timing();
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL abort_pending got=%b exp=0", cfg_ready); end
    while (k < 33) tick();
    checks++; if (hcount !== 4'd5 || vcount !== 3'd2) begin failures++; $display("FAIL abort_position got=%0d,%0d exp=5,2", hcount, vcount); end
    rst_n = 1'b0;
    #1;
    checks++; if (hcount !== 4'd0 || vcount !== 3'd0) begin failures++; $display("FAIL abort_counters got=%0d,%0d exp=0,0", hcount, vcount); end
    checks++; if (cfg_ready !== 1'b1 || cfg_applied !== 1'b0) begin failures++; $display("FAIL abort_cfg got ready=%b applied=%b exp 1,0", cfg_ready, cfg_applied); end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k <= 130) begin
      eh = k % 14;
      ev = (k / 14) % 8;
      checks++; if (hcount !== 4'(eh) || vcount !== 3'(ev)) begin failures++; $display("FAIL abort_resume k=%0d got=%0d,%0d exp=%0d,%0d", k, hcount, vcount, eh, ev); end
      checks++; if (cfg_applied !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL abort_no_apply k=%0d got applied=%b ready=%b exp 0,1", k, cfg_applied, cfg_ready); end
      tick();
    end
  endtask
`else
  // Fixed-timing build: cfg port is inert.
  task automatic test_no_runtime_cfg();
    int eh, ev;
    do_reset();
    set_new_timing();
    cfg_valid = 1'b1;
    while (k <= 130) begin
      eh = k % 14;
      ev = (k / 14) % 8;
      checks++; if (hcount !== 4'(eh) || vcount !== 3'(ev)) begin failures++; $display("FAIL nocfg_count k=%0d got=%0d,%0d exp=%0d,%0d", k, hcount, vcount, eh, ev); end
      checks++; if (cfg_ready !== 1'b0 || cfg_applied !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL nocfg_outputs k=%0d got=%b%b%b exp=000", k, cfg_ready, cfg_applied, cfg_err); end
      tick();
    end
    cfg_valid = 1'b0;
  endtask
`endif

  initial begin
    cfg_timing = '0;
    test_reset();
    test_count();
`ifdef VTG_RUNTIME_CFG_EN
    test_cfg_apply();
    test_cfg_reject();
    test_cfg_frame_end();
    test_reset_abort();
`else
    test_no_runtime_cfg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
